fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the pipelined core: owns the PC, issues requests to
//  instruction memory over a req/gnt + rvalid handshake, and hands instructions to decode
//  with a valid/ready handshake.
//  Applies branch/jump redirects from EX at any point. Kills an in-flight response that
//  belongs to the old path. One outstanding memory request at a time.
// PARAMETERS
//  PC_W      `PC_WIDTH (32)  program counter / imem address width
//  INST_W    32              instruction word width
//  RESET_PC  0               PC loaded on reset
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       reset, asynchronous, active-high
//  redirect_valid  in   1       EX redirect (taken branch/jump) this cycle
//  redirect_pc     in   PC_W    redirect target (pc + imm)
//  imem_req        out  1       fetch request to instruction memory
//  imem_addr       out  PC_W    fetch address, bits[1:0] always 0
//  imem_gnt        in   1       memory accepted request this cycle
//  imem_rvalid     in   1       response valid (>=1 cycle after gnt)
//  imem_rdata      in   INST_W  response instruction word
//  inst_valid      out  1       instruction available to decode
//  inst            out  INST_W  instruction word
//  inst_pc         out  PC_W    address of inst
//  inst_ready      in   1       decode accepts inst this cycle
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, state=IDLE, kill=0, imem_req=0, imem_addr=RESET_PC.
//    Also inst_valid=0, inst=0, inst_pc=0.
//  Non-reset states:
//  - IDLE: one cycle after reset release, go to REQ.
//  - REQ: imem_req=1, imem_addr=pc. On imem_gnt: req_pc<=pc, pc<=pc+4, go to WAIT.
//  - WAIT: imem_req=0. On imem_rvalid:
//      kill=1: discard response, kill<=0, go to REQ.
//      kill=0: inst<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, go to HOLD.
//  - HOLD: inst/inst_pc/inst_valid held stable. On inst_ready: inst_valid<=0, go to REQ.
//  Latency and throughput:
//  - gnt->inst_valid = rvalid latency + 1 register stage.
//  - Max throughput is one instruction per 3 cycles with 1-cycle memory. Accepted.
//  Redirect (highest priority, any non-IDLE state):
//  - pc<=redirect_pc with bits[1:0] forced to 0.
//  - REQ, no gnt: stay REQ. imem_addr shows the new pc next cycle.
//  - REQ with gnt: go to WAIT with kill<=1, and pc is not incremented.
//  - WAIT, no rvalid: kill<=1.
//  - WAIT with rvalid: discard that response and go to REQ.
//  - HOLD: inst_valid<=0 and go to REQ. This also applies when inst_ready is high the
//    same cycle; decode flushes on redirect.
//  - Redirect in IDLE: pc is updated, and the FSM still proceeds to REQ.
//  - Back-to-back redirects: the last one wins. kill never exceeds 1, since only one
//    request is outstanding.
//  Width rules:
//  - pc+4 wraps modulo 2^PC_W, e.g. 32'hFFFF_FFFC -> 32'h0000_0000.
//  - An imem_rvalid in IDLE/REQ/HOLD is a protocol error: ignore it; an assertion fires
//    in simulation.
//  Reset mid-operation: all state clears immediately. A pending response arriving after
//  reset release is ignored because it arrives in IDLE/REQ.
// STRUCTURE
//  - Shared constants (PC_WIDTH, INST_WIDTH, NOP encoding) live in riscv_def.v. Add:
//      FS_IDLE=2'd0, FS_REQ=2'd1, FS_WAIT=2'd2, FS_HOLD=2'd3.
//  - One sub-module, fetch_pc_gen: PC register plus the next-pc mux
//    (hold / +4 / redirect with alignment).
//  - The FSM, kill flag and output register stay in fetch_sequencer.
// TESTING
//  1. Reset release, gnt same cycle as req, rvalid 1 cycle later with 32'h00000013,
//     inst_ready=1.
//     -> Fetches addr 0, 4, 8 in order; each inst_pc matches its addr.
//  2. Hold inst_ready=0 for 5 cycles in HOLD.
//     -> inst/inst_pc stay stable, imem_req=0 throughout; next fetch starts after ready.
//  3. Redirect to 32'h100 while in WAIT, then rvalid.
//     -> That response is dropped, inst_valid stays 0, next imem_addr=32'h100.
//  4. Redirect to 32'h203 with gnt in the same REQ cycle.
//     -> kill set, response discarded, next imem_addr=32'h200.
//  5. Start at pc=32'hFFFFFFFC, with RESET_PC set there.
//     -> After gnt, next imem_addr=32'h0.
//  6. Assert rst in WAIT, release it, then the stale rvalid arrives.
//     -> All outputs zero; the stale response is ignored; a fresh fetch starts from
//        RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;
  localparam int PC_STEP    = 4;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_REQ  = 2'd1;
  localparam logic [1:0] FS_WAIT = 2'd2;
  localparam logic [1:0] FS_HOLD = 2'd3;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-pc selection: hold, sequential step, or
// word-aligned redirect target.
module fetch_pc_gen
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W     = PC_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  logic [PC_W-1:0] pc_next;

  // The sequential step wraps naturally at the top of the address space.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:      pc_next = pc + PC_W'(PC_STEP);
      PC_REDIRECT: pc_next = redirect_pc & ALIGN_MASK;
      default:     pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives one outstanding imem request at a time,
// registers the response for decode and squashes responses from a stale path.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W     = PC_WIDTH,
  parameter int              INST_W   = INST_WIDTH,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            kill;
  logic            kill_nxt;
  logic            load_inst;
  logic            drop_inst;
  logic            stale_ok;
  pc_sel_t         pc_sel;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;

  fetch_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst         (rst),
    .sel         (pc_sel),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  assign imem_req  = (state == FS_REQ);
  assign imem_addr = pc;

  // A redirect always wins the pc, even if the request was granted this cycle.
  always_comb begin
    if (redirect_valid) begin
      pc_sel = PC_REDIRECT;
    end else if (state == FS_REQ && imem_gnt) begin
      pc_sel = PC_INC;
    end else begin
      pc_sel = PC_HOLD;
    end
  end

  always_comb begin
    state_nxt = state;
    kill_nxt  = kill;
    load_inst = 1'b0;
    drop_inst = 1'b0;
    case (state)
      FS_IDLE: begin
        state_nxt = FS_REQ;
      end
      FS_REQ: begin
        if (imem_gnt) begin
          state_nxt = FS_WAIT;
          if (redirect_valid) begin
            kill_nxt = 1'b1;
          end
        end
      end
      FS_WAIT: begin
        if (imem_rvalid) begin
          kill_nxt = 1'b0;
          if (kill || redirect_valid) begin
            state_nxt = FS_REQ;
          end else begin
            load_inst = 1'b1;
            state_nxt = FS_HOLD;
          end
        end else if (redirect_valid) begin
          kill_nxt = 1'b1;
        end
      end
      FS_HOLD: begin
        // Decode flushes on redirect, so an accept in the same cycle is moot.
        if (inst_ready || redirect_valid) begin
          drop_inst = 1'b1;
          state_nxt = FS_REQ;
        end
      end
      default: begin
        state_nxt = FS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FS_IDLE;
      kill  <= 1'b0;
    end else begin
      state <= state_nxt;
      kill  <= kill_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc <= '0;
    end else if (state == FS_REQ && imem_gnt) begin
      req_pc <= pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else if (load_inst) begin
      inst_valid <= 1'b1;
      inst       <= imem_rdata;
      inst_pc    <= req_pc;
    end else if (drop_inst) begin
      inst_valid <= 1'b0;
    end
  end

  // A response still in flight across a reset may legally land before the
  // first new grant; outside that window rvalid must only come in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stale_ok <= 1'b1;
    end else if (imem_req && imem_gnt) begin
      stale_ok <= 1'b0;
    end
  end

  rvalid_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> (state == FS_WAIT || stale_ok));

endmodule
